// File: rtl/ras_resolve_queue.sv
// In-order queue of front-end RAS predictions, checked against resolved return targets.
// Define RAS_RESOLVE_STATS_EN to add saturating resolve/mispredict statistics counters.
module ras_resolve_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VLEN  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [VLEN-1:0]            enq_ra_i,
  input  logic                       enq_ra_valid_i,
  input  logic                       res_valid_i,
  input  logic [VLEN-1:0]            res_target_i,
  output logic                       mispredict_o,
  output logic [VLEN-1:0]            mispredict_target_o,
  output logic                       underflow_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef RAS_RESOLVE_STATS_EN
  ,
  output logic [31:0]                stat_resolved_o,
  output logic [31:0]                stat_mispred_o
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [VLEN-1:0] ra_q [DEPTH];
  logic [DEPTH-1:0] rav_q;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             mispredict_q, mispredict_d;
  logic             underflow_q, underflow_d;
  logic [VLEN-1:0]  mp_target_q, mp_target_d;

  logic enq_fire, res_pop, res_empty, mismatch, do_mp, do_write;

  assign enq_ready_o         = (count_q != CntFull);
  assign count_o             = count_q;
  assign mispredict_o        = mispredict_q;
  assign mispredict_target_o = mp_target_q;
  assign underflow_o         = underflow_q;

  always_comb begin
    enq_fire  = enq_valid_i && enq_ready_o;
    res_pop   = res_valid_i && (count_q != '0);
    res_empty = res_valid_i && (count_q == '0);
    // An invalid RAS prediction can never be trusted, whatever its address.
    mismatch  = !rav_q[rptr_q] || (ra_q[rptr_q] != res_target_i);
    do_mp     = !flush_i && res_pop && mismatch;
    do_write  = !flush_i && !do_mp && enq_fire;

    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    mispredict_d = do_mp;
    underflow_d  = !flush_i && res_empty;
    mp_target_d  = do_mp ? res_target_i : mp_target_q;

    if (flush_i || do_mp) begin
      // Everything younger than the resolving return is wrong-path, including a same-cycle enqueue.
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) wptr_d = wptr_q + PtrW'(1);
      if (res_pop)  rptr_d = rptr_q + PtrW'(1);
      unique case ({enq_fire, res_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
      underflow_q  <= 1'b0;
      mp_target_q  <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      mispredict_q <= mispredict_d;
      underflow_q  <= underflow_d;
      mp_target_q  <= mp_target_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ra_q[i] <= '0;
      end
      rav_q <= '0;
    end else if (do_write) begin
      ra_q[wptr_q]  <= enq_ra_i;
      rav_q[wptr_q] <= enq_ra_valid_i;
    end
  end

`ifdef RAS_RESOLVE_STATS_EN
  logic [31:0] stat_res_q, stat_mp_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_res_q <= '0;
      stat_mp_q  <= '0;
    end else begin
      if (!flush_i && res_pop && (stat_res_q != '1)) stat_res_q <= stat_res_q + 32'd1;
      if (do_mp && (stat_mp_q != '1))                 stat_mp_q  <= stat_mp_q + 32'd1;
    end
  end

  assign stat_resolved_o = stat_res_q;
  assign stat_mispred_o  = stat_mp_q;
`endif

endmodule
